// File: rtl/rtype_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rtype_pkg: shared FSM states, R-type encodings and legality check   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package rtype_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLDW = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [5:0]  OPC_RTYPE = 6'h00;
  localparam logic [5:0]  FUNCT_ADD = 6'h20;
  localparam logic [5:0]  FUNCT_SUB = 6'h22;
  localparam logic [5:0]  FUNCT_AND = 6'h24;
  localparam logic [5:0]  FUNCT_OR  = 6'h25;
  localparam logic [5:0]  FUNCT_SLT = 6'h2A;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic is_legal_rtype(input logic [31:0] w);
    logic funct_ok;
    funct_ok = (w[5:0] == FUNCT_ADD) || (w[5:0] == FUNCT_SUB) ||
               (w[5:0] == FUNCT_AND) || (w[5:0] == FUNCT_OR)  ||
               (w[5:0] == FUNCT_SLT);
    return (w[31:26] == OPC_RTYPE) && funct_ok;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtype_issue_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rtype_issue_ctrl_if: host load / control / datapath bundle          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface rtype_issue_ctrl_if #(
  parameter int INSTR_W = 32
);
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_instr;
  logic               ld_ready;
  logic               start;
  logic               busy;
  logic               done;
  logic [INSTR_W-1:0] dp_instr;
  logic               dp_zf;
  logic [7:0]         issued_cnt;
  logic [7:0]         zf_cnt;
  logic [7:0]         illegal_cnt;

  modport master (
    output ld_valid, ld_instr, start, dp_zf,
    input  ld_ready, busy, done, dp_instr, issued_cnt, zf_cnt, illegal_cnt
  );

  modport slave (
    input  ld_valid, ld_instr, start, dp_zf,
    output ld_ready, busy, done, dp_instr, issued_cnt, zf_cnt, illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with wrap-bit pointers, show-ahead read|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Same index with opposite wrap bit means the writer has lapped the reader.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/rtype_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rtype_issue_ctrl: issues buffered R-type words to the datapath      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rtype_issue_ctrl
  import rtype_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 32,
  parameter int HOLD    = 2
) (
  input wire logic         clk,
  input wire logic         rst_n,
  rtype_issue_ctrl_if.slave bus
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e             state_q;
  logic [HW-1:0]      hold_q;
  logic [INSTR_W-1:0] dp_instr_q;
  logic               done_q;
  logic [7:0]         issued_q;
  logic [7:0]         zf_q;
  logic [7:0]         illegal_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               ld_ready_d;
  logic               pop_d;

  assign ld_ready_d = rst_n && (state_q == ST_IDLE) && !fifo_full;
  assign pop_d      = (state_q == ST_ISSUE);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.ld_valid && ld_ready_d),
    .wr_data_i (bus.ld_instr),
    .rd_en_i   (pop_d),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      dp_instr_q <= INSTR_W'(NOP_INSTR);
      done_q     <= 1'b0;
      issued_q   <= 8'd0;
      zf_q       <= 8'd0;
      illegal_q  <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            issued_q  <= 8'd0;
            zf_q      <= 8'd0;
            illegal_q <= 8'd0;
            state_q   <= fifo_empty ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (is_legal_rtype(fifo_head[31:0])) begin
            dp_instr_q <= fifo_head;
          end else begin
            dp_instr_q <= INSTR_W'(NOP_INSTR);
            illegal_q  <= sat_inc(illegal_q);
          end
          hold_q  <= HW'(HOLD - 1);
          state_q <= ST_HOLDW;
        end
        ST_HOLDW: begin
          // The zero flag is sampled on the final hold cycle of each word.
          if (hold_q == '0) begin
            issued_q <= sat_inc(issued_q);
            if (bus.dp_zf) zf_q <= sat_inc(zf_q);
            state_q <= fifo_empty ? ST_DONE : ST_ISSUE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q     <= 1'b1;
          dp_instr_q <= INSTR_W'(NOP_INSTR);
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ld_ready    = ld_ready_d;
  assign bus.busy        = (state_q == ST_ISSUE) || (state_q == ST_HOLDW);
  assign bus.done        = done_q;
  assign bus.dp_instr    = dp_instr_q;
  assign bus.issued_cnt  = issued_q;
  assign bus.zf_cnt      = zf_q;
  assign bus.illegal_cnt = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_rtype_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rtype_issue_ctrl: directed + randomized checks against a model   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_rtype_issue_ctrl;
  localparam int DEPTH = 16;
  localparam int HOLD  = 2;
  localparam int P     = HOLD + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtype_issue_ctrl_if #(.INSTR_W(32)) bus ();

  rtype_issue_ctrl #(
    .DEPTH   (DEPTH),
    .INSTR_W (32),
    .HOLD    (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_q [$];
  bit          zf_pat  [$];
  bit          noise   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference legality rule: opcode zero and one of five supported functs.
  function automatic bit ref_legal(input logic [31:0] w);
    logic [5:0] f;
    f = w[5:0];
    return (w[31:26] == 6'd0) &&
           (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
  endfunction

  function automatic logic [31:0] gen_word();
    logic [5:0] fl [5];
    int r;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r  = int'($urandom_range(0, 3));
    if (r < 2) return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, fl[$urandom_range(0, 4)]};
    if (r == 2) return {6'd0, 20'($urandom), 6'h21};
    return $urandom;
  endfunction

  task automatic load(input logic [31:0] w);
    bit acc;
    bus.ld_valid = 1'b1;
    bus.ld_instr = w;
    acc = (model_q.size() < DEPTH);
    chk("ld_ready_load", 32'(bus.ld_ready), 32'(acc));
    @(posedge clk);
    if (acc) model_q.push_back(w);
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),        32'd0);
    chk({tag, "_done"},     32'(bus.done),        32'd0);
    chk({tag, "_dp_instr"}, bus.dp_instr,         32'd0);
    chk({tag, "_issued"},   32'(bus.issued_cnt),  32'd0);
    chk({tag, "_zf"},       32'(bus.zf_cnt),      32'd0);
    chk({tag, "_illegal"},  32'(bus.illegal_cnt), 32'd0);
  endtask

  // Runs the modelled program; abort_k >= 0 applies reset after that many post-start edges.
  task automatic run_prog(input int abort_k);
    int          n;
    int          exp_ill;
    int          exp_zf;
    logic [31:0] exp_dp [$];
    n       = model_q.size();
    exp_ill = 0;
    exp_zf  = 0;
    while (zf_pat.size() < n) zf_pat.push_back(1'($urandom));
    for (int i = 0; i < n; i++) begin
      exp_dp.push_back(ref_legal(model_q[i]) ? model_q[i] : 32'd0);
      if (!ref_legal(model_q[i])) exp_ill++;
      if (zf_pat[i]) exp_zf++;
    end
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k <= n * P + 2; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk_reset_state("abort");
        rst_n = 1'b1;
        model_q.delete();
        zf_pat.delete();
        return;
      end
      chk("busy",     32'(bus.busy),     32'(k < n * P));
      chk("done",     32'(bus.done),     32'(k == n * P + 1));
      chk("ld_ready", 32'(bus.ld_ready), 32'(k > n * P));
      if ((k % P) != 0 && k < n * P) chk("dp_instr", bus.dp_instr, exp_dp[k / P]);
      if (k == n * P + 1) begin
        chk("dp_nop",      bus.dp_instr,              32'd0);
        chk("issued_cnt",  32'(bus.issued_cnt),  32'(n));
        chk("zf_cnt",      32'(bus.zf_cnt),      32'(exp_zf));
        chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(exp_ill));
      end
      if (((k + 1) % P) == 0 && ((k + 1) / P - 1) < n) bus.dp_zf = zf_pat[(k + 1) / P - 1];
      else bus.dp_zf = noise ? 1'($urandom) : 1'b0;
      // Loads offered while the block is busy must be dropped.
      bus.ld_valid = (k <= n * P) ? noise : 1'b0;
      bus.ld_instr = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    bus.dp_zf    = 1'b0;
    model_q.delete();
    zf_pat.delete();
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_instr = '0;
    bus.start    = 1'b0;
    bus.dp_zf    = 1'b0;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    chk("reset_ld_ready", 32'(bus.ld_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ld_ready", 32'(bus.ld_ready), 32'd1);

    // ADD then SUB, zero flag only on the second sample.
    load(32'h00EA_4020);
    load(32'h03D4_6022);
    zf_pat.push_back(1'b0);
    zf_pat.push_back(1'b1);
    run_prog(-1);

    // Illegal opcode and illegal funct both become NOP.
    load(32'hFC00_0000);
    load(32'h0000_0021);
    run_prog(-1);

    // Overfill: the seventeenth word is dropped.
    for (int i = 0; i < DEPTH + 1; i++) load(gen_word());
    chk("full_model_size", 32'(model_q.size()), 32'(DEPTH));
    noise = 1'b1;
    run_prog(-1);

    // Zero-work start clears counters and finishes one cycle later.
    run_prog(-1);

    // Randomized programs.
    for (int r = 0; r < 3; r++) begin
      int len;
      len = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < len; i++) load(gen_word());
      run_prog(-1);
    end

    // Reset during the third of five words: no done, FIFO flushed.
    for (int i = 0; i < 5; i++) load(gen_word());
    run_prog(2 * P + 1);
    for (int i = 0; i < 3; i++) begin
      chk("post_abort_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    run_prog(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
